instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage feeding the single-cycle core's instruction input. Owns the fetch PC, fetches
//  32-bit words from instruction memory over a req/ack handshake with variable latency, and
//  buffers them in a small prefetch queue. Presents {instruction, pc} to the core with
//  valid/ready. Flushes and restarts on a branch/jump redirect from the core.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset; must be 4-byte aligned
//  QDEPTH    2              prefetch queue entries (power of 2, >=2)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  nrst         in   1   asynchronous active-low reset
//  imem_req     out  1   fetch request; held high until imem_ack
//  imem_addr    out  32  word address of the request; stable while imem_req=1
//  imem_ack     in   1   one-cycle pulse; imem_rdata is valid in that cycle
//  imem_rdata   in   32  fetched instruction word
//  redirect     in   1   one-cycle pulse from core on taken branch, JAL or JALR
//  redirect_pc  in   32  target address, sampled when redirect=1
//  instr_ready  in   1   core accepts the head entry this cycle
//  instr_valid  out  1   instruction/pc hold a valid entry
//  instruction  out  32  head instruction word
//  pc           out  32  address of the head instruction
//  misaligned   out  1   sticky flag: last redirect target had [1:0]!=0
// BEHAVIOUR
//  Reset (asynchronous, nrst=0): fetch_pc=RESET_PC, queue empty, state=IDLE, imem_req=0,
//   imem_addr=RESET_PC, instr_valid=0, instruction=32'h0000_0013 (NOP), pc=RESET_PC,
//   misaligned=0. nrst asserted mid-transaction abandons any in-flight request; a late
//   imem_ack after reset release is ignored unless imem_req=1.
//  At most one outstanding request. A request is issued only if (queue count + outstanding)
//   < QDEPTH.
//  FSM states:
//   IDLE -> REQ   when there is space, misaligned=0 and no redirect this cycle
//   REQ  -> IDLE  on imem_ack: push {fetch_pc, imem_rdata}; fetch_pc += 4 (mod 2^32, so
//                 32'hFFFF_FFFC wraps to 0). Go straight back to REQ if space remains, giving
//                 back-to-back requests (1 instr/cycle when memory acks in the same cycle).
//   REQ  -> DROP  on redirect without ack: imem_req stays high until ack (no abort)
//   DROP -> IDLE  on imem_ack: discard the data; fetch from the redirect target
//  Latency: imem_ack in cycle N -> entry visible at instr_valid in cycle N+1 (registered queue).
//  Handshake: pop when instr_valid && instr_ready. A push and a pop in the same cycle with a
//   full queue are both legal; count stays unchanged.
//  Redirect (highest priority):
//   - Flushes the queue and drops any pop in the same cycle; instr_valid=0 the next cycle.
//   - Sets fetch_pc = {redirect_pc[31:2], 2'b00}.
//   - redirect coinciding with imem_ack: the acked data is discarded and the state goes to IDLE.
//   - If redirect_pc[1:0] != 0: misaligned is set and fetching halts (IDLE, no requests) until
//     the next aligned redirect or reset. An aligned redirect clears misaligned.
//  Output mux: instr_valid=0 drives instruction=NOP and pc=last valid pc. Outputs are never X.
//  Full queue: no new request is issued. Empty queue: instr_valid=0.
// STRUCTURE
//  fetch_pkg: fetch_state_t {IDLE, REQ, DROP}, NOP_INSTR=32'h0000_0013, PC_STEP=32'd4.
//  Sub-module fetch_queue: synchronous FIFO (QDEPTH x 64 bits, {pc, instr}) with push, pop,
//   flush, count, full and empty. Flush takes priority over push and pop.
//  Top level contains the FSM, fetch_pc register, space check and output mux.
// TESTING
//  1 Reset release, memory acks 1 cycle after req, words 32'h3e800093/32'h83000113 -> first
//    imem_addr=0; instr_valid=1 with pc=0 then pc=4 in order; instruction matches each word.
//  2 instr_ready=0 with QDEPTH=2 -> exactly 2 acks are taken, then imem_req stays 0; raising
//    instr_ready resumes requests at addr 8.
//  3 Redirect to 32'h0000_03E8 while req is outstanding (ack 3 cycles later) -> that data is
//    dropped, the next imem_addr=0x3E8, and the first delivered pc=0x3E8.
//  4 Redirect in the same cycle as imem_ack and a pop -> no entry delivered from the old
//    stream; instr_valid=0 the next cycle.
//  5 Redirect to 32'h0000_03EA -> misaligned=1, no requests issued; then redirect to 0x100 ->
//    misaligned=0 and the fetch at 0x100 resumes.
//  6 RESET_PC=32'hFFFF_FFF8, continuous acks -> pcs FFFF_FFF8, FFFF_FFFC, 0000_0000;
//    nrst pulsed mid-REQ -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (IDLE, REQ, DROP)
//   fetch_entry_t : prefetch queue entry {pc, instr}
//   NOP_INSTR     : instruction presented when no entry is valid (addi x0,x0,0)
//   PC_STEP       : sequential fetch increment
//   align_pc()    : forces a target address onto a word boundary
`timescale 1ns/1ps
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO holding prefetched {pc, instr} entries.
// Flush has priority over push and pop. A push into a full queue is accepted
// only when a pop happens in the same cycle, so the count stays unchanged.
// Ports:
//   clk, nrst    clock, asynchronous active-low reset
//   i_push       write i_push_data at the tail
//   i_push_data  entry to write
//   i_pop        remove the head entry (ignored when empty)
//   i_flush      discard every entry
//   o_head       head entry (contents undefined when o_empty)
//   o_count      number of stored entries
//   o_full       o_count == DEPTH
//   o_empty      o_count == 0
`timescale 1ns/1ps
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count,
  output logic         o_full,
  output logic         o_empty
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  fetch_entry_t  r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only ever read after
  // it has been written, and leaving it out of reset keeps it plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage feeding the core. Owns the fetch PC, issues one
// outstanding req/ack fetch at a time, buffers words in fetch_queue and presents
// {instruction, pc} with valid/ready. A redirect flushes and restarts fetching.
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   imem_req / imem_addr      fetch request (held until ack) and word address
//   imem_ack / imem_rdata     one-cycle completion pulse and fetched word
//   redirect / redirect_pc    branch/jump restart pulse and target
//   instr_ready               core accepts the head entry
//   instr_valid               head entry valid
//   instruction / pc          head entry (NOP / last valid pc when not valid)
//   misaligned                sticky: last redirect target was not word aligned
`timescale 1ns/1ps
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        misaligned
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_drop_addr;
  logic [31:0]  r_last_pc;
  logic         r_misaligned;

  fetch_entry_t  w_head;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_count_after;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_space_after;

  // Acked data is kept only in REQ and only when no redirect kills it.
  assign w_push = (r_state == REQ) && imem_ack && !redirect;
  assign w_pop  = instr_valid && instr_ready && !redirect;

  // Occupancy after this cycle's push/pop decides whether the next request
  // can be issued straight away (back-to-back fetching).
  assign w_count_after = {1'b0, w_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};
  assign w_space_after = (w_count_after < (CW+1)'(QDEPTH));

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk         (clk),
    .nrst        (nrst),
    .i_push      (w_push),
    .i_push_data ('{pc: r_fetch_pc, instr: imem_rdata}),
    .i_pop       (w_pop),
    .i_flush     (redirect),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // NOTE: next-state logic takes a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (!redirect && !r_misaligned && !w_full) w_state_next = REQ;
      REQ: begin
        if (redirect)      w_state_next = imem_ack ? IDLE : DROP;
        else if (imem_ack) w_state_next = w_space_after ? REQ : IDLE;
      end
      DROP:    if (imem_ack) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= IDLE;
      r_fetch_pc   <= RESET_PC;
      r_drop_addr  <= RESET_PC;
      r_last_pc    <= RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (redirect) begin
        r_fetch_pc   <= align_pc(redirect_pc);
        r_misaligned <= |redirect_pc[1:0];
      end else if ((r_state == REQ) && imem_ack) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
      // The abandoned request keeps its address on the bus until acked.
      if ((r_state == REQ) && redirect && !imem_ack) r_drop_addr <= r_fetch_pc;
      if (!w_empty) r_last_pc <= w_head.pc;
    end
  end

  assign imem_req    = (r_state != IDLE);
  assign imem_addr   = (r_state == DROP) ? r_drop_addr : r_fetch_pc;
  assign instr_valid = !w_empty;
  assign instruction = instr_valid ? w_head.instr : NOP_INSTR;
  assign pc          = instr_valid ? w_head.pc : r_last_pc;
  assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] W0 = 32'h3e80_0093;
  localparam logic [31:0] W1 = 32'h8300_0113;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0)
  logic        nrst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        misaligned;

  // Wrap-around instance (RESET_PC = FFFF_FFF8)
  logic        wp_nrst;
  logic        wp_req;
  logic [31:0] wp_addr;
  logic        wp_ack;
  logic [31:0] wp_rdata;
  logic        wp_ready;
  logic        wp_valid;
  logic [31:0] wp_instr;
  logic [31:0] wp_pc;
  logic        wp_mis;
  logic        wp_ack_en;

  int n_compared   = 0;
  int n_mismatched = 0;

  fetch_entry_t sb[$];

  // Memory model controls
  bit          mem_auto;
  int          mem_lat;
  int          lat_cnt;
  int          ack_count = 0;
  logic        auto_ack;
  logic [31:0] auto_rdata;
  logic        man_ack;
  logic [31:0] man_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return W0;
    if (a == 32'h4) return W1;
    return a ^ 32'h1357_9BDF;
  endfunction

  instr_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk(clk), .nrst(nrst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_ready(instr_ready), .instr_valid(instr_valid),
    .instruction(instruction), .pc(pc), .misaligned(misaligned)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut_wrap (
    .clk(clk), .nrst(wp_nrst),
    .imem_req(wp_req), .imem_addr(wp_addr),
    .imem_ack(wp_ack), .imem_rdata(wp_rdata),
    .redirect(1'b0), .redirect_pc(32'h0),
    .instr_ready(wp_ready), .instr_valid(wp_valid),
    .instruction(wp_instr), .pc(wp_pc), .misaligned(wp_mis)
  );

  assign imem_ack   = mem_auto ? auto_ack : man_ack;
  assign imem_rdata = mem_auto ? auto_rdata : man_rdata;
  // Zero-latency memory for the wrap instance: acks in the cycle of the request.
  assign wp_ack     = wp_req && wp_ack_en;
  assign wp_rdata   = mem_word(wp_addr);

  // Auto memory responder: acks mem_lat cycles after the request is first seen.
  initial begin
    auto_ack = 1'b0; auto_rdata = '0; lat_cnt = 0;
    forever begin
      @(posedge clk); #1;
      auto_ack = 1'b0;
      if (!nrst || !imem_req || !mem_auto) lat_cnt = 0;
      else if (lat_cnt >= mem_lat) begin
        auto_ack   = 1'b1;
        auto_rdata = mem_word(imem_addr);
        lat_cnt    = 0;
        ack_count++;
      end else lat_cnt++;
    end
  end

  // Scoreboard monitor: every accepted instruction must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (nrst && instr_valid && instr_ready && !redirect) begin
        n_compared++;
        if (sb.size() == 0) begin
          n_mismatched++;
          $display("FAIL delivery: got pc=%h instr=%h, required none", pc, instruction);
        end else begin
          fetch_entry_t e;
          e = sb.pop_front();
          if (pc !== e.pc || instruction !== e.instr) begin
            n_mismatched++;
            $display("FAIL delivery: got pc=%h instr=%h, required pc=%h instr=%h",
                     pc, instruction, e.pc, e.instr);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int lat);
    nrst = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    mem_auto = 1'b1; mem_lat = lat; man_ack = 1'b0; man_rdata = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic wait_req(input string what, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (imem_req) begin seen = 1'b1; break; end
    end
    n_compared++;
    if (!seen) begin
      n_mismatched++;
      $display("FAIL %s: imem_req=0 after %0d cycles, required 1", what, budget);
    end
  endtask

  task automatic wait_ack(input string what, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (imem_ack) begin seen = 1'b1; break; end
    end
    n_compared++;
    if (!seen) begin
      n_mismatched++;
      $display("FAIL %s: imem_ack=0 after %0d cycles, required 1", what, budget);
    end
  endtask

  task automatic wait_drain(input string what, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin done = 1'b1; break; end
    end
    instr_ready = 1'b0;
    n_compared++;
    if (!done) begin
      n_mismatched++;
      $display("FAIL %s: %0d entries undelivered, required 0", what, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_addr(input string what, input logic [31:0] exp);
    n_compared++;
    if (imem_addr !== exp) begin
      n_mismatched++;
      $display("FAIL %s: imem_addr=%h, required %h", what, imem_addr, exp);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    mem_auto = 1'b1; mem_lat = 1; man_ack = 1'b0; man_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_compared++;
    if ({imem_req, imem_addr, instr_valid, instruction, pc, misaligned} !==
        {1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0, 1'b0}) begin
      n_mismatched++;
      $display("FAIL reset: req=%b addr=%h valid=%b instr=%h pc=%h mis=%b, required 0/0/0/%h/0/0",
               imem_req, imem_addr, instr_valid, instruction, pc, misaligned, NOP_INSTR);
    end
  endtask

  task automatic test_fetch_in_order();
    do_reset(1);
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) sb.push_back('{pc: 32'(i * 4), instr: mem_word(32'(i * 4))});
    wait_req("first_req", 10);
    check_addr("first_addr", 32'h0);
    wait_ack("first_ack", 10);
    n_compared++;
    if (instr_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL latency_ack_cycle: instr_valid=%b, required 0", instr_valid);
    end
    @(negedge clk);
    n_compared++;
    if (instr_valid !== 1'b1 || pc !== 32'h0) begin
      n_mismatched++;
      $display("FAIL latency_next_cycle: valid=%b pc=%h, required 1/00000000", instr_valid, pc);
    end
    wait_drain("in_order_drain", 60);
  endtask

  task automatic test_backpressure();
    int a0;
    do_reset(1);
    a0 = ack_count;
    repeat (14) @(posedge clk);
    #1;
    n_compared++;
    if (ack_count - a0 != 2 || imem_req !== 1'b0) begin
      n_mismatched++;
      $display("FAIL full_stall: acks=%0d req=%b, required 2/0", ack_count - a0, imem_req);
    end
    n_compared++;
    if (instr_valid !== 1'b1 || pc !== 32'h0 || instruction !== W0) begin
      n_mismatched++;
      $display("FAIL full_head: valid=%b pc=%h instr=%h, required 1/00000000/%h",
               instr_valid, pc, instruction, W0);
    end
    for (int i = 0; i < 3; i++) sb.push_back('{pc: 32'(i * 4), instr: mem_word(32'(i * 4))});
    instr_ready = 1'b1;
    wait_req("resume_req", 10);
    check_addr("resume_addr", 32'h8);
    wait_drain("backpressure_drain", 40);
  endtask

  task automatic test_redirect_drop();
    do_reset(3);
    instr_ready = 1'b1;
    wait_req("drop_first_req", 10);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h0000_03E8;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    n_compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_mismatched++;
      $display("FAIL drop_hold: req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
    end
    wait_ack("drop_ack", 10);
    sb.push_back('{pc: 32'h3E8, instr: mem_word(32'h3E8)});
    sb.push_back('{pc: 32'h3EC, instr: mem_word(32'h3EC)});
    wait_req("redirect_req", 10);
    check_addr("redirect_addr", 32'h0000_03E8);
    wait_drain("redirect_drain", 60);
  endtask

  task automatic test_redirect_ack_pop();
    do_reset(1);
    mem_auto = 1'b0;
    wait_req("manual_req", 10);
    @(posedge clk); #1;
    man_ack = 1'b1; man_rdata = W0;
    @(posedge clk); #1;
    // Head (pc 0) now valid; ack, pop and redirect all land in this cycle.
    man_ack = 1'b1; man_rdata = W1;
    redirect = 1'b1; redirect_pc = 32'h0000_0200; instr_ready = 1'b1;
    @(posedge clk); #1;
    man_ack = 1'b0; redirect = 1'b0;
    @(negedge clk);
    n_compared++;
    if (instr_valid !== 1'b0 || instruction !== NOP_INSTR || pc !== 32'h0) begin
      n_mismatched++;
      $display("FAIL flush_outputs: valid=%b instr=%h pc=%h, required 0/%h/00000000",
               instr_valid, instruction, pc, NOP_INSTR);
    end
    sb.push_back('{pc: 32'h200, instr: mem_word(32'h200)});
    wait_req("post_flush_req", 10);
    check_addr("post_flush_addr", 32'h0000_0200);
    @(posedge clk); #1;
    man_ack = 1'b1; man_rdata = mem_word(32'h200);
    @(posedge clk); #1;
    man_ack = 1'b0;
    wait_drain("flush_drain", 10);
    mem_auto = 1'b1;
  endtask

  task automatic test_misaligned();
    int req_cycles = 0;
    do_reset(1);
    repeat (10) @(posedge clk);
    #1;
    redirect = 1'b1; redirect_pc = 32'h0000_03EA;
    @(posedge clk); #1;
    redirect = 1'b0;
    n_compared++;
    if (misaligned !== 1'b1 || instr_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL misaligned_set: mis=%b valid=%b, required 1/0", misaligned, instr_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req) req_cycles++;
    end
    n_compared++;
    if (req_cycles != 0) begin
      n_mismatched++;
      $display("FAIL misaligned_halt: req cycles=%0d, required 0", req_cycles);
    end
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(posedge clk); #1;
    redirect = 1'b0;
    n_compared++;
    if (misaligned !== 1'b0) begin
      n_mismatched++;
      $display("FAIL misaligned_clear: mis=%b, required 0", misaligned);
    end
    sb.push_back('{pc: 32'h100, instr: mem_word(32'h100)});
    sb.push_back('{pc: 32'h104, instr: mem_word(32'h104)});
    instr_ready = 1'b1;
    wait_req("aligned_req", 10);
    check_addr("aligned_addr", 32'h0000_0100);
    wait_drain("aligned_drain", 40);
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] exp_pcs[$];
    int cyc = 0;
    exp_pcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    @(negedge clk);
    n_compared++;
    if ({wp_req, wp_addr, wp_valid, wp_instr, wp_pc, wp_mis} !==
        {1'b0, 32'hFFFF_FFF8, 1'b0, NOP_INSTR, 32'hFFFF_FFF8, 1'b0}) begin
      n_mismatched++;
      $display("FAIL wrap_reset: req=%b addr=%h valid=%b instr=%h pc=%h mis=%b, required 0/fffffff8/0/%h/fffffff8/0",
               wp_req, wp_addr, wp_valid, wp_instr, wp_pc, wp_mis, NOP_INSTR);
    end
    @(posedge clk); #1;
    wp_nrst = 1'b1; wp_ready = 1'b1; wp_ack_en = 1'b1;
    while (exp_pcs.size() != 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (wp_valid) begin
        logic [31:0] e;
        e = exp_pcs.pop_front();
        n_compared++;
        if (wp_pc !== e || wp_instr !== mem_word(e)) begin
          n_mismatched++;
          $display("FAIL wrap_seq: got pc=%h instr=%h, required pc=%h instr=%h",
                   wp_pc, wp_instr, e, mem_word(e));
        end
      end
    end
    n_compared++;
    if (exp_pcs.size() != 0) begin
      n_mismatched++;
      $display("FAIL wrap_timeout: %0d pcs undelivered, required 0", exp_pcs.size());
    end
    @(posedge clk); #1;
    n_compared++;
    if (wp_req !== 1'b1) begin
      n_mismatched++;
      $display("FAIL wrap_busy: req=%b, required 1", wp_req);
    end
    wp_nrst = 1'b0;
    #1;
    n_compared++;
    if ({wp_req, wp_addr, wp_valid, wp_instr, wp_pc, wp_mis} !==
        {1'b0, 32'hFFFF_FFF8, 1'b0, NOP_INSTR, 32'hFFFF_FFF8, 1'b0}) begin
      n_mismatched++;
      $display("FAIL async_reset: req=%b addr=%h valid=%b instr=%h pc=%h mis=%b, required 0/fffffff8/0/%h/fffffff8/0",
               wp_req, wp_addr, wp_valid, wp_instr, wp_pc, wp_mis, NOP_INSTR);
    end
  endtask

  initial begin
    wp_nrst = 1'b0; wp_ready = 1'b0; wp_ack_en = 1'b0;
    test_reset();
    test_fetch_in_order();
    test_backpressure();
    test_redirect_drop();
    test_redirect_ack_pop();
    test_misaligned();
    test_wrap_and_reset();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
